// File: rtl/sdm_cic_decimator_if.sv
// Purpose: sample bus for the SDM CIC decimator (1-bit stream in, 16-bit PCM out).
// Latency: n/a (wires only).
// Backpressure: none; the bit source drives valid_in freely, the consumer must take every valid_out strobe.
//   master (bit source / sample sink): drives valid_in, sdm_in; observes valid_out, audio_out
//   slave  (decimator):                 observes valid_in, sdm_in; drives valid_out, audio_out
interface sdm_cic_decimator_if;
    logic               valid_in;
    logic               sdm_in;
    logic               valid_out;
    logic signed [15:0] audio_out;

    modport master (
        output valid_in,
        output sdm_in,
        input  valid_out,
        input  audio_out
    );

    modport slave (
        input  valid_in,
        input  sdm_in,
        output valid_out,
        output audio_out
    );
endinterface

// File: rtl/sdm_cic_decimator.sv
// Purpose: CIC decimator turning a 1-bit sigma-delta stream into saturated 16-bit signed PCM.
// Latency: valid_out pulses 2 edges after the edge accepting the last bit of each R-bit block.
// Backpressure: none; a bit is accepted on every cycle with valid_in high, output is a strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sdm_cic_decimator_if (valid_in/sdm_in in, valid_out/audio_out out)
module sdm_cic_decimator #(
    parameter int ORDER  = 3,
    parameter int LOG2_R = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    sdm_cic_decimator_if.slave bus
);
    localparam int W  = ORDER * LOG2_R + 2;
    localparam int SH = ORDER * LOG2_R - 15;
    localparam int WC = $clog2(ORDER + 1);

    localparam logic signed [W-1:0] POS_MAX = W'(32767);
    localparam logic signed [W-1:0] NEG_MIN = W'(-32768);

    logic signed [W-1:0] x;
    logic signed [W-1:0] integ      [ORDER];
    logic signed [W-1:0] integ_nxt  [ORDER];
    logic [LOG2_R-1:0]   phase;
    logic                dec_edge;
    logic                dec_strobe;
    logic signed [W-1:0] dec_sample;
    logic signed [W-1:0] comb_in    [ORDER];
    logic signed [W-1:0] comb_dly   [ORDER];
    logic signed [W-1:0] comb_res;
    logic signed [W-1:0] comb_out;
    logic                comb_vld;
    logic [WC-1:0]       warm_cnt;
    logic signed [W-1:0] scaled;
    logic signed [15:0]  sat;

    assign x        = bus.sdm_in ? W'(1) : '1;
    assign dec_edge = bus.valid_in && (phase == '1);

    // Integrator cascade evaluated combinationally so that the last stage
    // already includes the bit accepted on the decimation edge.
    always_comb begin
        logic signed [W-1:0] acc;
        acc = x;
        for (int k = 0; k < ORDER; k++) begin
            acc          = integ[k] + acc;
            integ_nxt[k] = acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) integ[k] <= '0;
            phase      <= '0;
            dec_sample <= '0;
            dec_strobe <= 1'b0;
        end else begin
            dec_strobe <= dec_edge;
            if (bus.valid_in) begin
                for (int k = 0; k < ORDER; k++) integ[k] <= integ_nxt[k];
                phase <= phase + 1'b1;
            end
            if (dec_edge) dec_sample <= integ_nxt[ORDER-1];
        end
    end

    // Comb cascade: stage k sees comb_in[k] and subtracts its own delayed input.
    always_comb begin
        logic signed [W-1:0] acc;
        acc = dec_sample;
        for (int k = 0; k < ORDER; k++) begin
            comb_in[k] = acc;
            acc        = acc - comb_dly[k];
        end
        comb_res = acc;
    end

    // The first ORDER decimated samples are filter transients: they still
    // advance the comb delays but are never presented on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) comb_dly[k] <= '0;
            comb_out <= '0;
            comb_vld <= 1'b0;
            warm_cnt <= '0;
        end else begin
            comb_vld <= 1'b0;
            if (dec_strobe) begin
                for (int k = 0; k < ORDER; k++) comb_dly[k] <= comb_in[k];
                comb_out <= comb_res;
                if (warm_cnt == WC'(ORDER)) begin
                    comb_vld <= 1'b1;
                end else begin
                    warm_cnt <= warm_cnt + 1'b1;
                end
            end
        end
    end

    // Gain is R**ORDER; dropping SH bits puts full scale at +/-2**15,
    // so +full scale lands one above 32767 and is clipped.
    assign scaled = comb_out >>> SH;

    always_comb begin
        sat = scaled[15:0];
        if (scaled > POS_MAX) sat = 16'sh7fff;
        else if (scaled < NEG_MIN) sat = 16'sh8000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_out <= 1'b0;
            bus.audio_out <= '0;
        end else begin
            bus.valid_out <= comb_vld;
            if (comb_vld) bus.audio_out <= sat;
        end
    end
endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Purpose: self-checking bench for sdm_cic_decimator against a direct-convolution CIC model.
// Latency: model expects each sample 2 edges after the edge completing its R-bit block.
// Backpressure: none exercised; the bench consumes every strobe.
module tb_sdm_cic_decimator;
    localparam int ORDER  = 3;
    localparam int LOG2_R = 6;
    localparam int R      = 1 << LOG2_R;
    localparam int SH     = ORDER * LOG2_R - 15;

    logic clk = 1'b0;
    logic rst_n;
    sdm_cic_decimator_if bus ();

    sdm_cic_decimator #(.ORDER(ORDER), .LOG2_R(LOG2_R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int glitches = 0;
    logic signed [15:0] last_audio = '0;

    int h[];          // impulse response of ORDER cascaded length-R boxcars
    int hist[$];      // accepted bits as +1/-1 since last reset
    int exp_t[$];
    int exp_v[$];
    int obs_t[$];
    int obs_v[$];
    int cont_vals[$];

    function automatic void build_kernel();
        int tmp[];
        h = new[1];
        h[0] = 1;
        for (int o = 0; o < ORDER; o++) begin
            tmp = new[h.size() + R - 1];
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < R; j++)
                    tmp[i + j] += h[i];
            h = tmp;
        end
    endfunction

    // Filtered value at the newest accepted bit, scaled and clipped to 16 bits.
    function automatic int model_sample();
        longint acc = 0;
        longint y;
        int n = hist.size();
        for (int j = 0; j < h.size(); j++)
            if (n - 1 - j >= 0) acc += longint'(h[j]) * longint'(hist[n - 1 - j]);
        y = acc >>> SH;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    task automatic step(input logic v, input logic b);
        bus.valid_in = v;
        bus.sdm_in   = b;
        @(posedge clk);
        cyc++;
        if (v) begin
            hist.push_back(b ? 1 : -1);
            if ((hist.size() % R) == 0 && (hist.size() / R) > ORDER) begin
                exp_t.push_back(cyc + 2);
                exp_v.push_back(model_sample());
            end
        end
        #1;
        if (bus.valid_out === 1'b1) begin
            obs_t.push_back(cyc);
            obs_v.push_back(int'(bus.audio_out));
            last_audio = bus.audio_out;
        end else if (bus.audio_out !== last_audio) begin
            glitches++;
        end
    endtask

    task automatic clear_model();
        hist.delete();
        exp_t.delete();
        exp_v.delete();
        obs_t.delete();
        obs_v.delete();
        last_audio = '0;
        glitches   = 0;
        cyc        = 0;
    endtask

    task automatic do_reset();
        bus.valid_in = 1'b0;
        bus.sdm_in   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid_out: got %0b expected 0", bus.valid_out);
        end
        checks++;
        if (bus.audio_out !== 16'sd0) begin
            errors++; $display("FAIL reset_audio_out: got %0d expected 0", bus.audio_out);
        end
        repeat (20) step(1'b0, 1'($urandom));
        checks++;
        if (obs_t.size() != 0 || glitches != 0) begin
            errors++; $display("FAIL idle_no_output: got %0d strobes %0d changes expected 0 0", obs_t.size(), glitches);
        end
    endtask

    task automatic test_all_ones();
        do_reset();
        repeat (256 + 4 * R) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (obs_t.size() != 5 || exp_t.size() != 5) begin
            errors++; $display("FAIL ones_count: got %0d model %0d expected 5", obs_t.size(), exp_t.size());
        end
        checks++;
        if (obs_t.size() == 0 || obs_t[0] != 258) begin
            errors++; $display("FAIL ones_first_time: got %0d expected 258", obs_t.size() ? obs_t[0] : -1);
        end
        for (int i = 0; i < obs_v.size(); i++) begin
            checks++;
            if (obs_v[i] != 32767 || i >= exp_v.size() || obs_v[i] != exp_v[i] || obs_t[i] != exp_t[i]) begin
                errors++; $display("FAIL ones_sample[%0d]: got %0d at %0d expected 32767", i, obs_v[i], obs_t[i]);
            end
        end
        checks++;
        if (glitches != 0) begin
            errors++; $display("FAIL ones_hold: got %0d changes expected 0", glitches);
        end
    endtask

    task automatic test_all_zeros();
        do_reset();
        repeat (6 * R) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (obs_t.size() != 3) begin
            errors++; $display("FAIL zeros_count: got %0d expected 3", obs_t.size());
        end
        for (int i = 0; i < obs_v.size(); i++) begin
            checks++;
            if (obs_v[i] != -32768 || i >= exp_t.size() || obs_t[i] != exp_t[i]) begin
                errors++; $display("FAIL zeros_sample[%0d]: got %0d at %0d expected -32768", i, obs_v[i], obs_t[i]);
            end
        end
    endtask

    task automatic test_pattern_1110();
        do_reset();
        for (int i = 0; i < 8 * R; i++) step(1'b1, (i % 4) != 3);
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (obs_t.size() != exp_t.size() || obs_t.size() != 5) begin
            errors++; $display("FAIL p1110_count: got %0d expected %0d", obs_t.size(), exp_t.size());
        end
        cont_vals = obs_v;
        for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
            checks++;
            if (obs_v[i] != 16384 || obs_v[i] != exp_v[i] || obs_t[i] != exp_t[i]) begin
                errors++; $display("FAIL p1110_sample[%0d]: got %0d at %0d expected 16384 at %0d", i, obs_v[i], obs_t[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_alternating();
        do_reset();
        for (int i = 0; i < 6 * R; i++) step(1'b1, (i % 2) == 0);
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (obs_t.size() != 3) begin
            errors++; $display("FAIL alt_count: got %0d expected 3", obs_t.size());
        end
        for (int i = 0; i < obs_v.size(); i++) begin
            checks++;
            if (obs_v[i] != 0 || i >= exp_t.size() || obs_t[i] != exp_t[i]) begin
                errors++; $display("FAIL alt_sample[%0d]: got %0d at %0d expected 0", i, obs_v[i], obs_t[i]);
            end
        end
    endtask

    task automatic test_gapped();
        int k = 0;
        do_reset();
        for (int i = 0; i < 3 * 8 * R; i++) begin
            if (i % 3 == 2) begin
                step(1'b1, (k % 4) != 3);
                k++;
            end else begin
                step(1'b0, 1'($urandom));
            end
        end
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (obs_v.size() != cont_vals.size() || obs_v.size() != exp_v.size()) begin
            errors++; $display("FAIL gap_count: got %0d expected %0d", obs_v.size(), cont_vals.size());
        end
        for (int i = 0; i < obs_v.size() && i < cont_vals.size() && i < exp_v.size(); i++) begin
            checks++;
            if (obs_v[i] != cont_vals[i] || obs_v[i] != exp_v[i] || obs_t[i] != exp_t[i]) begin
                errors++; $display("FAIL gap_sample[%0d]: got %0d at %0d expected %0d at %0d", i, obs_v[i], obs_t[i], cont_vals[i], exp_t[i]);
            end
            if (i > 0) begin
                checks++;
                if (obs_t[i] - obs_t[i-1] != 3 * R) begin
                    errors++; $display("FAIL gap_spacing[%0d]: got %0d expected %0d", i, obs_t[i] - obs_t[i-1], 3 * R);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (4 * R + 37) step(1'b1, 1'b1);
        checks++;
        if (bus.audio_out !== 16'sd32767) begin
            errors++; $display("FAIL midrst_pre_audio: got %0d expected 32767", bus.audio_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.audio_out !== 16'sd0) begin
            errors++; $display("FAIL midrst_clear: got valid %0b audio %0d expected 0 0", bus.valid_out, bus.audio_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
        repeat (256 + R) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (obs_t.size() != 2 || obs_t[0] != 258 || obs_v[0] != 32767) begin
            errors++; $display("FAIL midrst_first: got %0d strobes first at %0d value %0d expected 2 at 258 value 32767",
                               obs_t.size(), obs_t.size() ? obs_t[0] : -1, obs_v.size() ? obs_v[0] : 0);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (2000) step(1'($urandom_range(0, 3) != 0), 1'($urandom));
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (obs_t.size() != exp_t.size() || obs_t.size() < 3) begin
            errors++; $display("FAIL rand_count: got %0d expected %0d", obs_t.size(), exp_t.size());
        end
        for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
            checks++;
            if (obs_v[i] != exp_v[i] || obs_t[i] != exp_t[i]) begin
                errors++; $display("FAIL rand_sample[%0d]: got %0d at %0d expected %0d at %0d", i, obs_v[i], obs_t[i], exp_v[i], exp_t[i]);
            end
        end
        checks++;
        if (glitches != 0) begin
            errors++; $display("FAIL rand_hold: got %0d changes expected 0", glitches);
        end
    endtask

    initial begin
        build_kernel();
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_pattern_1110();
        test_alternating();
        test_gapped();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdm_cic_decimator.md
Name: sdm_cic_decimator

Overview:
- Downstream stage of the sigma-delta modulator: converts a 1-bit SDM bitstream back to 16-bit signed PCM audio.
- Uses a CIC decimation filter: ORDER integrators at bit rate, decimation by R = 2**LOG2_R, then ORDER combs at output rate.
- Output is scaled and saturated to 16 bits, with a one-cycle valid strobe per output sample.
- One instance per audio channel on the ADC path.

Parameters:
ORDER, 3, number of integrator and comb stages; legal range 1..5
LOG2_R, 6, log2 of decimation ratio R (default R=64); legal range 2..8; ORDER*LOG2_R must be >= 15
W, ORDER*LOG2_R+2, internal accumulator width (derived, not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  qualifies sdm_in; one accepted bit per cycle where high
sdm_in  input  1  SDM bit; 1 -> +1, 0 -> -1
valid_out  output  1  one-cycle strobe, audio_out holds a new sample
audio_out  output  16  signed PCM sample

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. rst_n low clears immediately:
  - all integrators, comb delay registers and the phase counter to 0
  - warm-up counter to 0
  - valid_out=0, audio_out=0
- Reset mid-operation discards all partial state. The first output after deassertion follows the warm-up rule below.
- Input mapping: each accepted bit becomes a W-bit signed +1 or -1.
- Integrators:
  - Update only on edges with valid_in=1: I1+=x, Ik+=I(k-1).
  - They use W-bit two's-complement wrap-around; overflow wrap is intended and must not saturate.
  - With valid_in=0, all state holds; gaps of any length are transparent.
- Phase counter:
  - LOG2_R bits; increments on each accepted bit and wraps R-1 -> 0.
  - The edge accepting the bit at phase R-1 is the decimation edge.
  - The integrator-ORDER value including that bit is latched into a decimated-sample register, and an internal dec_strobe is set for one cycle.
- Combs:
  - Evaluated on the cycle dec_strobe=1, in W-bit wrap arithmetic: Ck = C(k-1) - D(k-1), with each delay register Dk updated to its input.
  - The result is registered on the following edge.
- Scaling: y = Cout >>> (ORDER*LOG2_R-15), arithmetic shift. Saturate y to [-32768, 32767].
  - Full-scale +R**ORDER maps to 32767 after saturation.
  - Full-scale -R**ORDER maps to -32768.
- Latency: valid_out goes high 2 clock edges after the decimation edge, for exactly one cycle.
  - audio_out updates on that same edge and holds until the next update.
- Warm-up:
  - The first ORDER decimated outputs after reset are filter transients. They update internal state but do not assert valid_out or change audio_out.
  - The first emitted sample is output ORDER+1, i.e. after (ORDER+1)*R accepted bits.
  - The warm-up counter saturates; it is cleared only by reset.
- Simultaneous events:
  - valid_in is accepted every cycle, including the decimation edge and cycles where valid_out=1. There is no backpressure and no input stall.
  - The comb pipeline is busy only 2 cycles per R accepted bits, so it cannot overrun even when valid_in is continuously high (R>=4).
- Data invariance: output values depend only on the sequence of accepted bits, never on valid_in gap timing (only the valid_out timing shifts).

Test Plan:
- Defaults, reset, then valid_in=1 continuously with sdm_in=1.
  - No valid_out during the first 192 accepted bits.
  - First valid_out is 2 edges after the 256th bit; audio_out=32767, and every later sample is 32767.
- Continuous sdm_in=0 -> every emitted sample = -32768.
- Repeating pattern 1,1,1,0 continuous -> settled samples = 16384.
- Alternating pattern 1,0 continuous -> settled samples = 0.
- Pattern 1,1,1,0 with valid_in high only every 3rd cycle, with invalid cycles carrying random sdm_in.
  - Sample values are identical to the contiguous run.
  - valid_out spacing is 3*64 cycles.
- Reset asserted asynchronously mid-frame (phase 37) while running all-ones:
  - valid_out and audio_out are 0 immediately.
  - After release, the first valid_out again appears only after 256 accepted bits, with value 32767.
